// File: rtl/alu_seq_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if : operand/result handshake and PSR-load bundle for alu_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] Opcode;
  logic [BIT_WIDTH-1:0]    Rdest;
  logic [BIT_WIDTH-1:0]    Rsrc_Imm;
  logic                    out_valid;
  logic                    out_ready;
  logic [BIT_WIDTH-1:0]    Result;
  logic [FLAG_WIDTH-1:0]   Flags;
  logic                    psr_we;
  logic [FLAG_WIDTH-1:0]   psr_din;

  modport master (
    output in_valid, Opcode, Rdest, Rsrc_Imm, out_ready, psr_we, psr_din,
    input  in_ready, out_valid, Result, Flags
  );

  modport slave (
    input  in_valid, Opcode, Rdest, Rsrc_Imm, out_ready, psr_we, psr_din,
    output in_ready, out_valid, Result, Flags
  );

endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq : registered ALU with {C,L,F,Z,N} PSR, valid/ready and iterative MUL
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5
) (
  input  wire       clk,
  input  wire       rst_n,
  alu_seq_if.slave  bus
);

  localparam int C_SH_W  = $clog2(BIT_WIDTH) + 1;
  localparam int C_CNT_W = $clog2(BIT_WIDTH);
  localparam int C_FC    = 4;
  localparam int C_FL    = 3;
  localparam int C_FF    = 2;
  localparam int C_FZ    = 1;
  localparam int C_FN    = 0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDC = 4'd2,
    OP_SUB  = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_LSH  = 4'd9,
    OP_RSH  = 4'd10,
    OP_ARSH = 4'd11,
    OP_MUL  = 4'd12
  } op_t;

  state_t                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   result_q, result_d;
  logic                   out_valid_q, out_valid_d;
  logic [FLAG_WIDTH-1:0]  psr_q, psr_d;
  logic [BIT_WIDTH-1:0]   acc_q, acc_d;
  logic [BIT_WIDTH-1:0]   mcand_q, mcand_d;
  logic [BIT_WIDTH-1:0]   mplier_q, mplier_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [3:0]              w_op_hi, w_op_lo;
  op_t                     w_op;
  logic [BIT_WIDTH-1:0]    w_a, w_b;
  logic                    w_busy, w_accept;
  logic                    w_cin;
  logic [BIT_WIDTH:0]      w_sum_ext, w_diff_ext;
  logic                    w_add_ovf, w_sub_ovf, w_slt;
  logic [C_SH_W-1:0]       w_lsh_amt, w_lsh_mag;
  logic                    w_lsh_neg;
  logic [BIT_WIDTH-1:0]    w_lsh, w_rsh, w_arsh;
  logic [BIT_WIDTH-1:0]    w_alu_res;
  logic                    w_alu_wr, w_upd_z;
  logic [FLAG_WIDTH-1:0]   w_alu_psr;
  logic [BIT_WIDTH-1:0]    w_mul_sum;
  logic                    w_fin, w_fin_wr;
  logic [BIT_WIDTH-1:0]    w_fin_res;
  logic [FLAG_WIDTH-1:0]   w_fin_psr;

  assign w_opcode = bus.Opcode;
  assign w_op_hi  = w_opcode[7:4];
  assign w_op_lo  = w_opcode[3:0];
  assign w_a      = bus.Rdest;
  assign w_b      = bus.Rsrc_Imm;

  assign w_busy        = (state_q == S_MUL);
  assign bus.in_ready  = !w_busy && (!out_valid_q || bus.out_ready);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Flags     = psr_q;

  // Register-form ops live in the 0x0_ row; the high nibble selects immediate forms.
  always_comb begin
    w_op = OP_NOP;
    case (w_op_hi)
      4'h0: begin
        case (w_op_lo)
          4'h1:       w_op = OP_AND;
          4'h2:       w_op = OP_OR;
          4'h3:       w_op = OP_XOR;
          4'h4:       w_op = OP_NOT;
          4'h5, 4'h6: w_op = OP_ADD;
          4'h7:       w_op = OP_ADDC;
          4'h9:       w_op = OP_SUB;
          4'hB:       w_op = OP_CMP;
          4'hE:       w_op = OP_MUL;
          default:    w_op = OP_NOP;
        endcase
      end
      4'h5, 4'h6: w_op = OP_ADD;
      4'h7:       w_op = OP_ADDC;
      4'h9:       w_op = OP_SUB;
      4'hB:       w_op = OP_CMP;
      4'h8: begin
        case (w_op_lo)
          4'h0, 4'h1, 4'h4:       w_op = OP_LSH;
          4'h8, 4'h9, 4'hA, 4'hB: w_op = OP_RSH;
          4'h2, 4'h3, 4'h6:       w_op = OP_ARSH;
          default:                w_op = OP_NOP;
        endcase
      end
      default: w_op = OP_NOP;
    endcase
  end

  assign w_cin      = (w_op == OP_ADDC) ? psr_q[C_FC] : 1'b0;
  assign w_sum_ext  = {1'b0, w_a} + {1'b0, w_b} + {{BIT_WIDTH{1'b0}}, w_cin};
  assign w_diff_ext = {1'b0, w_a} - {1'b0, w_b};
  assign w_add_ovf  = (w_a[BIT_WIDTH-1] == w_b[BIT_WIDTH-1]) &&
                      (w_sum_ext[BIT_WIDTH-1] != w_a[BIT_WIDTH-1]);
  assign w_sub_ovf  = (w_a[BIT_WIDTH-1] != w_b[BIT_WIDTH-1]) &&
                      (w_diff_ext[BIT_WIDTH-1] != w_a[BIT_WIDTH-1]);
  assign w_slt      = $signed(w_a) < $signed(w_b);

  // LSH takes a signed amount: negative values shift right logically.
  assign w_lsh_amt = w_b[C_SH_W-1:0];
  assign w_lsh_neg = w_lsh_amt[C_SH_W-1];
  assign w_lsh_mag = w_lsh_neg ? (~w_lsh_amt + C_SH_W'(1)) : w_lsh_amt;
  assign w_lsh     = (w_lsh_mag >= C_SH_W'(BIT_WIDTH)) ? '0 :
                     (w_lsh_neg ? (w_a >> w_lsh_mag) : (w_a << w_lsh_mag));
  assign w_rsh     = (w_b >= BIT_WIDTH'(BIT_WIDTH)) ? '0 : (w_a >> w_b);
  assign w_arsh    = (w_b >= BIT_WIDTH'(BIT_WIDTH)) ? {BIT_WIDTH{w_a[BIT_WIDTH-1]}} :
                     $unsigned($signed(w_a) >>> w_b);

  always_comb begin
    w_alu_res = '0;
    w_alu_wr  = 1'b1;
    w_upd_z   = 1'b1;
    w_alu_psr = psr_q;
    case (w_op)
      OP_ADD, OP_ADDC: begin
        w_alu_res         = w_sum_ext[BIT_WIDTH-1:0];
        w_alu_psr[C_FC]   = w_sum_ext[BIT_WIDTH];
        w_alu_psr[C_FF]   = w_add_ovf;
      end
      OP_SUB: begin
        w_alu_res         = w_diff_ext[BIT_WIDTH-1:0];
        w_alu_psr[C_FC]   = w_diff_ext[BIT_WIDTH];
        w_alu_psr[C_FF]   = w_sub_ovf;
      end
      OP_CMP: begin
        w_alu_wr          = 1'b0;
        w_upd_z           = 1'b0;
        w_alu_psr[C_FZ]   = (w_a == w_b);
        w_alu_psr[C_FN]   = w_slt;
        w_alu_psr[C_FL]   = w_diff_ext[BIT_WIDTH];
      end
      OP_AND:  w_alu_res = w_a & w_b;
      OP_OR:   w_alu_res = w_a | w_b;
      OP_XOR:  w_alu_res = w_a ^ w_b;
      OP_NOT:  w_alu_res = ~w_b;
      OP_LSH:  w_alu_res = w_lsh;
      OP_RSH:  w_alu_res = w_rsh;
      OP_ARSH: w_alu_res = w_arsh;
      default: begin
        w_alu_wr = 1'b0;
        w_upd_z  = 1'b0;
      end
    endcase
    if (w_upd_z) begin
      w_alu_psr[C_FZ] = (w_alu_res == '0);
    end
  end

  assign w_mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      psr_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      psr_q       <= psr_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    psr_d       = psr_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    w_fin       = 1'b0;
    w_fin_wr    = 1'b0;
    w_fin_res   = result_q;
    w_fin_psr   = psr_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = w_a;
            mplier_d = w_b;
            cnt_d    = '0;
          end else begin
            w_fin     = 1'b1;
            w_fin_wr  = w_alu_wr;
            w_fin_res = w_alu_res;
            w_fin_psr = w_alu_psr;
          end
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle; the last step completes directly from the sum.
        acc_d    = w_mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + C_CNT_W'(1);
        if (cnt_q == C_CNT_W'(BIT_WIDTH - 1)) begin
          state_d         = S_IDLE;
          w_fin           = 1'b1;
          w_fin_wr        = 1'b1;
          w_fin_res       = w_mul_sum;
          w_fin_psr       = psr_q;
          w_fin_psr[C_FZ] = (w_mul_sum == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_fin) begin
      out_valid_d = 1'b1;
      psr_d       = w_fin_psr;
      if (w_fin_wr) begin
        result_d = w_fin_res;
      end
    end

    if (bus.psr_we) begin
      psr_d = bus.psr_din;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int BW = 16;
  localparam int OW = 8;
  localparam int FW = 5;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs [23];
  logic seen_ov;

  alu_seq_if #(.BIT_WIDTH(BW), .OPCODE_WIDTH(OW), .FLAG_WIDTH(FW)) bus_if ();

  alu_seq #(.BIT_WIDTH(BW), .OPCODE_WIDTH(OW), .FLAG_WIDTH(FW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    int waited;
    waited = 0;
    bus_if.Opcode   = op;
    bus_if.Rdest    = a;
    bus_if.Rsrc_Imm = b;
    bus_if.in_valid = 1'b1;
    while (!bus_if.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!bus_if.in_ready) check("send_ready_timeout", 32'd0, 32'd1);
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res, input logic [4:0] flg);
    check({tag, "_vld"}, bus_if.out_valid, 1);
    check({tag, "_res"}, bus_if.Result, res);
    check({tag, "_flg"}, bus_if.Flags, flg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'h04},  // ADD overflow
      '{8'h06, 16'hFFFF, 16'h0001, 16'h0000, 5'h12},  // ADDU carry, zero
      '{8'h07, 16'h0001, 16'h0001, 16'h0003, 5'h00},  // ADDC uses C
      '{8'h0B, 16'h0003, 16'hFFFF, 16'h0003, 5'h08},  // CMP
      '{8'h00, 16'h1111, 16'h2222, 16'h0003, 5'h08},  // NOP
      '{8'h84, 16'h0F0F, 16'hFFFC, 16'h00F0, 5'h08},  // LSH by -4
      '{8'h86, 16'h8000, 16'h0014, 16'hFFFF, 5'h08},  // ARSH by 20
      '{8'h88, 16'h8000, 16'h000F, 16'h0001, 5'h08},  // RSH by 15
      '{8'h8A, 16'h8000, 16'h0010, 16'h0000, 5'h0A},  // RSHI by 16
      '{8'h81, 16'h0001, 16'h0004, 16'h0010, 5'h08},  // LSHI by 4
      '{8'h84, 16'hFFFF, 16'h0010, 16'h0000, 5'h0A},  // LSH by -16
      '{8'h03, 16'h00FF, 16'h0FF0, 16'h0F0F, 5'h08},  // XOR
      '{8'h04, 16'h0000, 16'h1234, 16'hEDCB, 5'h08},  // NOT
      '{8'h93, 16'h0003, 16'h0005, 16'hFFFE, 5'h18},  // SUBI borrow
      '{8'h09, 16'h8000, 16'h0001, 16'h7FFF, 5'h0C},  // SUB overflow
      '{8'hB0, 16'hFFFF, 16'h0001, 16'h7FFF, 5'h05},  // CMPI signed less
      '{8'hFF, 16'h1234, 16'h5678, 16'h7FFF, 5'h05},  // unlisted
      '{8'h75, 16'h0001, 16'h0002, 16'h0003, 5'h01},  // ADDCI, C=0
      '{8'h01, 16'hF0F0, 16'h0F0F, 16'h0000, 5'h03},  // AND
      '{8'h02, 16'hF000, 16'h000F, 16'hF00F, 5'h01},  // OR
      '{8'h82, 16'h4000, 16'h0002, 16'h1000, 5'h01},  // ARSHI
      '{8'h50, 16'h7FFF, 16'hFFFF, 16'h7FFE, 5'h11},  // ADDI carry
      '{8'h07, 16'h0000, 16'h0000, 16'h0001, 5'h01}   // ADDC carry-in only
    };

    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.Opcode    = '0;
    bus_if.Rdest     = '0;
    bus_if.Rsrc_Imm  = '0;
    bus_if.out_ready = 1'b1;
    bus_if.psr_we    = 1'b0;
    bus_if.psr_din   = '0;
    repeat (3) tick();
    check("rst_result", bus_if.Result, 0);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_flags", bus_if.Flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", bus_if.in_ready, 1);

    for (int i = 0; i < 23; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      expect_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg);
    end
    tick();
    check("idle_valid_drop", bus_if.out_valid, 0);

    // MUL latency and busy window
    send(8'h0E, 16'h0012, 16'h0034);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mul_busy%0d", i), {bus_if.in_ready, bus_if.out_valid}, 0);
      tick();
    end
    expect_out("mul", 16'h03A8, 5'h01);
    check("mul_ready_after", bus_if.in_ready, 1);
    tick();

    // PSR load while MUL busy; completion overwrites Z only
    send(8'h0E, 16'h0002, 16'h0003);
    tick();
    bus_if.psr_we  = 1'b1;
    bus_if.psr_din = 5'h1F;
    tick();
    bus_if.psr_we  = 1'b0;
    check("psr_load_busy", bus_if.Flags, 5'h1F);
    for (int i = 0; i < 40 && !bus_if.out_valid; i++) tick();
    expect_out("mul_psr", 16'h0006, 5'h1D);
    tick();

    // Reset during MUL aborts it
    send(8'h0E, 16'h0012, 16'h0034);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", bus_if.out_valid, 0);
    check("abort_result", bus_if.Result, 0);
    check("abort_flags", bus_if.Flags, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_ready", bus_if.in_ready, 1);
    seen_ov = 1'b0;
    for (int i = 0; i < 24; i++) begin
      seen_ov |= bus_if.out_valid;
      tick();
    end
    check("abort_no_valid", seen_ov, 0);

    // Back-pressure: result holds, next instruction waits
    bus_if.out_ready = 1'b0;
    send(8'h05, 16'h0001, 16'h0002);
    expect_out("stall_add", 16'h0003, 5'h00);
    bus_if.Opcode   = 8'h05;
    bus_if.Rdest    = 16'h0010;
    bus_if.Rsrc_Imm = 16'h0010;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_ready%0d", i), bus_if.in_ready, 0);
      check($sformatf("stall_valid%0d", i), bus_if.out_valid, 1);
      check($sformatf("stall_result%0d", i), bus_if.Result, 16'h0003);
      tick();
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("stall_release_ready", bus_if.in_ready, 1);
    tick();
    bus_if.in_valid = 1'b0;
    expect_out("stall_next", 16'h0020, 5'h00);
    tick();
    check("stall_drop", bus_if.out_valid, 0);

    // psr_din wins over a completing instruction's flags
    bus_if.psr_we  = 1'b1;
    bus_if.psr_din = 5'h15;
    send(8'h05, 16'hFFFF, 16'h0001);
    bus_if.psr_we  = 1'b0;
    expect_out("psr_we_add", 16'h0000, 5'h15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
